// File: rtl/switch_egress_if.sv
// switch_egress_if: ingress transaction bundle and egress valid/ready stream of one egress arbiter
interface switch_egress_if #(parameter int NUM_PORTS = 4, parameter int DW = 8);
  logic [NUM_PORTS-1:0]    in_valid;
  logic [NUM_PORTS*4-1:0]  in_source;
  logic [NUM_PORTS*4-1:0]  in_target;
  logic [NUM_PORTS*DW-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [3:0]              out_source;
  logic [3:0]              out_target;
  logic [DW-1:0]           out_data;
  logic [NUM_PORTS*3-1:0]  fifo_level;
  logic                    drop_pulse;
  logic [7:0]              drop_count;
  modport master (
    output in_valid, in_source, in_target, in_data, out_ready,
    input  out_valid, out_source, out_target, out_data, fifo_level, drop_pulse, drop_count
  );
  modport slave (
    input  in_valid, in_source, in_target, in_data, out_ready,
    output out_valid, out_source, out_target, out_data, fifo_level, drop_pulse, drop_count
  );
endinterface

// File: rtl/switch_egress_arbiter.sv
// switch_egress_arbiter: per-ingress capture FIFOs for one egress port, round-robin merged
// onto a registered valid/ready stream with drop accounting.
module switch_egress_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int PORT_ID    = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int DW         = 8
) (
  input logic           clk,
  input logic           rst_n,
  switch_egress_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  localparam int EW = 4 + DW;
  typedef enum logic {EMPTY, HOLD} state_t;
  state_t state, state_n;
  logic [EW-1:0] mem [NUM_PORTS][FIFO_DEPTH];
  logic [AW:0] wr_ptr [NUM_PORTS];
  logic [AW:0] rd_ptr [NUM_PORTS];
  logic [AW:0] level [NUM_PORTS];
  logic [NUM_PORTS-1:0] req, full, nonempty, pop, push, drop;
  logic [PW-1:0] rr_ptr, win;
  logic load_en, grant, found;
  logic [7:0] ndrop, drop_count;
  logic [8:0] drop_sum;
  logic [3:0] out_source;
  logic [DW-1:0] out_data;
  logic drop_pulse;
  genvar g;
  generate
    for (g = 0; g < NUM_PORTS; g++) begin : g_fifo
      assign level[g] = wr_ptr[g] - rd_ptr[g];
      assign full[g] = level[g] == (AW+1)'(FIFO_DEPTH);
      assign nonempty[g] = level[g] != '0;
      assign req[g] = bus.in_valid[g] && bus.in_target[4*g+PORT_ID];
      // a full FIFO still accepts when the same cycle frees a slot
      assign push[g] = req[g] && (!full[g] || pop[g]);
      assign drop[g] = req[g] && full[g] && !pop[g];
      assign bus.fifo_level[3*g+:3] = 3'(level[g]);
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          wr_ptr[g] <= '0;
          rd_ptr[g] <= '0;
        end else begin
          if (push[g]) wr_ptr[g] <= wr_ptr[g] + 1'b1;
          if (pop[g]) rd_ptr[g] <= rd_ptr[g] + 1'b1;
        end
      always_ff @(posedge clk)
        if (push[g]) mem[g][wr_ptr[g][AW-1:0]] <= {bus.in_source[4*g+:4], bus.in_data[DW*g+:DW]};
    end
  endgenerate
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!found && nonempty[(int'(rr_ptr) + k) % NUM_PORTS]) begin
        win = PW'((int'(rr_ptr) + k) % NUM_PORTS);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    load_en = state == EMPTY || bus.out_ready;
    grant = load_en && found;
    pop = grant ? NUM_PORTS'(1) << win : '0;
    state_n = grant ? HOLD : load_en ? EMPTY : state;
  end
  always_comb begin
    ndrop = '0;
    for (int k = 0; k < NUM_PORTS; k++) ndrop = ndrop + 8'(drop[k]);
    drop_sum = {1'b0, drop_count} + {1'b0, ndrop};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= EMPTY;
      rr_ptr <= '0;
      out_source <= '0;
      out_data <= '0;
      drop_pulse <= 1'b0;
      drop_count <= '0;
    end else begin
      state <= state_n;
      drop_pulse <= |drop;
      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      if (grant) begin
        rr_ptr <= win == PW'(NUM_PORTS-1) ? '0 : win + 1'b1;
        {out_source, out_data} <= mem[win][rd_ptr[win][AW-1:0]];
      end
    end
  assign bus.out_valid = state == HOLD;
  assign bus.out_target = bus.out_valid ? 4'b1 << PORT_ID : 4'b0;
  assign bus.out_source = out_source;
  assign bus.out_data = out_data;
  assign bus.drop_pulse = drop_pulse;
  assign bus.drop_count = drop_count;
endmodule

// File: tb/tb_switch_egress_arbiter.sv
// tb_switch_egress_arbiter: directed checks of capture, round-robin order, overflow, hold and reset
module tb_switch_egress_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  switch_egress_if #(.NUM_PORTS(4), .DW(8)) bus ();
  switch_egress_arbiter #(.NUM_PORTS(4), .PORT_ID(2), .FIFO_DEPTH(4), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [2:0] lvl(input int p);
    return bus.fifo_level[3*p+:3];
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.in_valid = '0;
  endtask
  task automatic put(input int p, input logic [3:0] s, input logic [3:0] t, input logic [7:0] d);
    bus.in_valid[p] = 1'b1;
    bus.in_source[4*p+:4] = s;
    bus.in_target[4*p+:4] = t;
    bus.in_data[8*p+:8] = d;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    bus.out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
  endtask
  logic [7:0] exp_d [6] = '{8'h33, 8'h30, 8'h21, 8'h22, 8'h23, 8'h24};
  logic [3:0] exp_s [6] = '{4'b1000, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
  initial begin
    bus.in_valid = '0;
    bus.in_source = '0;
    bus.in_target = '0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    do_reset();
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_target", 32'(bus.out_target), 0);
    chk("rst_level", 32'(bus.fifo_level), 0);
    chk("rst_count", 32'(bus.drop_count), 0);
    chk("rst_pulse", 32'(bus.drop_pulse), 0);
    put(0, 4'b0001, 4'b0100, 8'hA5);
    step();
    idle();
    chk("t1_no_bypass", 32'(bus.out_valid), 0);
    chk("t1_level", 32'(lvl(0)), 1);
    step();
    chk("t1_valid", 32'(bus.out_valid), 1);
    chk("t1_source", 32'(bus.out_source), 32'h1);
    chk("t1_target", 32'(bus.out_target), 32'h4);
    chk("t1_data", 32'(bus.out_data), 32'hA5);
    chk("t1_level0", 32'(lvl(0)), 0);
    step();
    chk("t1_drain", 32'(bus.out_valid), 0);
    do_reset();
    for (int p = 0; p < 4; p++) put(p, 4'(1 << p), 4'b0100, 8'(8'h10 + p));
    step();
    idle();
    chk("t2_levels", 32'(bus.fifo_level), 32'b001_001_001_001);
    for (int p = 0; p < 4; p++) begin
      step();
      chk($sformatf("t2_src%0d", p), 32'(bus.out_source), 32'(1 << p));
      chk($sformatf("t2_data%0d", p), 32'(bus.out_data), 32'(8'h10 + p));
    end
    step();
    chk("t2_drain", 32'(bus.out_valid), 0);
    put(1, 4'b0010, 4'b0100, 8'h41);
    put(0, 4'b0001, 4'b0100, 8'h40);
    step();
    idle();
    step();
    chk("t2_wrap_first", 32'(bus.out_data), 32'h40);
    step();
    chk("t2_wrap_second", 32'(bus.out_data), 32'h41);
    step();
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      put(1, 4'b0010, 4'b0100, 8'(8'h20 + i));
      step();
      chk($sformatf("t3_level%0d", i), 32'(lvl(1)), i == 0 ? 1 : i == 5 ? 4 : i);
      chk($sformatf("t3_pulse%0d", i), 32'(bus.drop_pulse), i == 5 ? 1 : 0);
    end
    idle();
    chk("t3_count", 32'(bus.drop_count), 1);
    step();
    chk("t3_pulse_once", 32'(bus.drop_pulse), 0);
    chk("t3_count_hold", 32'(bus.drop_count), 1);
    put(0, 4'b0001, 4'b0100, 8'h30);
    put(3, 4'b1000, 4'b0100, 8'h33);
    for (int c = 0; c < 5; c++) begin
      step();
      idle();
      chk($sformatf("t4_hold_valid%0d", c), 32'(bus.out_valid), 1);
      chk($sformatf("t4_hold_data%0d", c), 32'(bus.out_data), 32'h20);
      chk($sformatf("t4_hold_src%0d", c), 32'(bus.out_source), 32'h2);
    end
    chk("t4_levels", 32'(bus.fifo_level), 32'b001_000_100_001);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("t4_data%0d", i), 32'(bus.out_data), 32'(exp_d[i]));
      chk($sformatf("t4_src%0d", i), 32'(bus.out_source), 32'(exp_s[i]));
    end
    step();
    chk("t4_drain", 32'(bus.out_valid), 0);
    put(3, 4'b0001, 4'b1011, 8'h55);
    step();
    idle();
    chk("t5_level3", 32'(lvl(3)), 0);
    chk("t5_count", 32'(bus.drop_count), 1);
    chk("t5_pulse", 32'(bus.drop_pulse), 0);
    step();
    chk("t5_valid", 32'(bus.out_valid), 0);
    bus.out_ready = 1'b0;
    put(0, 4'b0001, 4'b0100, 8'hA0);
    put(2, 4'b0100, 4'b0100, 8'hB0);
    step();
    put(0, 4'b0001, 4'b0100, 8'hA1);
    put(2, 4'b0100, 4'b0100, 8'hB1);
    step();
    idle();
    chk("t6_pre_valid", 32'(bus.out_valid), 1);
    chk("t6_pre_data", 32'(bus.out_data), 32'hB0);
    chk("t6_pre_level0", 32'(lvl(0)), 2);
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(bus.out_valid), 0);
    chk("t6_levels", 32'(bus.fifo_level), 0);
    chk("t6_count", 32'(bus.drop_count), 0);
    chk("t6_target", 32'(bus.out_target), 0);
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    chk("t6_after_valid", 32'(bus.out_valid), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
